// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: queues bytes from the control FSM and
// launches them one at a time with a one-clock active-low tx_en pulse.
//
// state       | meaning
// S_IDLE      | waiting for a queued byte; pops and launches it when present
// S_WAIT_LOW  | launch done; waiting for tx_complete_i to drop (transfer started)
// S_WAIT_HIGH | transfer in progress; waiting for tx_complete_i to rise
// S_GAP       | inter-byte idle gap of GAP_CYCLES clocks
module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_i,
  input  logic [7:0]               data_i,
  input  logic                     flush_i,
  input  logic                     clr_ovf_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     busy_o,
  output logic                     tx_en_o,
  output logic [7:0]               tx_byte_o,
  input  logic                     tx_complete_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOW  = 2'd1,
    S_WAIT_HIGH = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_next;
  logic [GW-1:0]   gap_cnt, gap_next;
  logic            push, pop, drop, launch;
  logic            tx_en_next, busy_next;
  logic [7:0]      tx_byte_next;

  // A flush in the launch cycle discards the head byte instead of sending it.
  assign launch = (state == S_IDLE) && !empty_o && !flush_i;
  assign pop    = launch;
  assign push   = wr_i && !full_o && !flush_i;
  assign drop   = wr_i && full_o;

  assign count_next = flush_i ? '0 : (count_o + CW'(push) - CW'(pop));

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count_o <= count_next;
      empty_o <= (count_next == '0);
      full_o  <= (count_next == CW'(DEPTH));
      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= S_IDLE;
      gap_cnt   <= '0;
      tx_en_o   <= 1'b1;
      tx_byte_o <= 8'h00;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_next;
      tx_en_o   <= tx_en_next;
      tx_byte_o <= tx_byte_next;
      busy_o    <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (launch) state_next = S_WAIT_LOW;
      S_WAIT_LOW:  if (!tx_complete_i) state_next = S_WAIT_HIGH;
      S_WAIT_HIGH: if (tx_complete_i) state_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:       if (gap_cnt == '0) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_en_next   = 1'b1;
    tx_byte_next = tx_byte_o;
    busy_next    = (state_next != S_IDLE);
    gap_next     = gap_cnt;
    if (launch) begin
      tx_en_next   = 1'b0;
      tx_byte_next = mem[rd_ptr];
    end
    if (state == S_WAIT_HIGH && tx_complete_i) begin
      gap_next = GAP_LOAD;
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_next = gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a UART transmitter model on the main
// instance, plus a second instance with an inter-byte gap driven by hand.
module tb_uart_tx_queue;

  typedef struct packed {
    logic       wr;
    logic [7:0] data;
    logic       flush;
    logic       clr;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, busy, tx_en;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       tx_complete = 1'b1;

  logic       g_wr = 1'b0;
  logic [7:0] g_data = 8'h00;
  logic       g_complete = 1'b1;
  logic       g_full, g_empty, g_ovf, g_busy, g_tx_en;
  logic [4:0] g_count;
  logic [7:0] g_tx_byte;

  int         checks = 0;
  int         failures = 0;

  logic       stall = 1'b0;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  int         rx_n = 0;
  logic [7:0] rx_mem [0:255];
  logic       overlap_seen = 1'b0;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(16), .GAP_CYCLES(0)) dut (
    .clk_i(clk), .reset_i(rst_n), .wr_i(wr), .data_i(data), .flush_i(flush),
    .clr_ovf_i(clr_ovf), .full_o(full), .empty_o(empty), .count_o(count),
    .overflow_o(overflow), .busy_o(busy), .tx_en_o(tx_en), .tx_byte_o(tx_byte),
    .tx_complete_i(tx_complete)
  );

  uart_tx_queue #(.DEPTH(16), .GAP_CYCLES(5)) dut_gap (
    .clk_i(clk), .reset_i(rst_n), .wr_i(g_wr), .data_i(g_data), .flush_i(1'b0),
    .clr_ovf_i(1'b0), .full_o(g_full), .empty_o(g_empty), .count_o(g_count),
    .overflow_o(g_ovf), .busy_o(g_busy), .tx_en_o(g_tx_en), .tx_byte_o(g_tx_byte),
    .tx_complete_i(g_complete)
  );

  // Transmitter model: takes a byte on a low tx_en, drops tx_complete, and
  // raises it again 20 clocks later unless the line is stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt = 0;
        tx_complete = 1'b1;
      end else if (m_busy) begin
        if (tx_en == 1'b0) overlap_seen = 1'b1;
        if (!stall) begin
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            tx_complete = 1'b1;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end
      end else if (tx_en == 1'b0) begin
        rx_mem[rx_n[7:0]] = tx_byte;
        rx_n = rx_n + 1;
        m_busy = 1'b1;
        m_cnt = 19;
        tx_complete = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    wr = 1'b0;
    flush = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int target, input int limit);
    int n = 0;
    while ((rx_n < target || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, (rx_n >= target && !busy), 1);
  endtask

  initial begin
    vec_t       vecs [8];
    logic [7:0] msg [4];
    int         base;
    int         peak;
    int         n;

    vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'hA3, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hA4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    msg[0] = 8'h4F; msg[1] = 8'h6B; msg[2] = 8'h0D; msg[3] = 8'h0A;

    // Reset values, held in reset and after release
    repeat (2) @(negedge clk);
    check("rst_tx_en", tx_en, 1);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_en_after", tx_en, 1);

    // Single byte latency
    base = rx_n;
    wr = 1'b1; data = 8'h4F;
    @(negedge clk);
    wr = 1'b0;
    check("lat_count_e", count, 1);
    check("lat_tx_en_e", tx_en, 1);
    @(negedge clk);
    check("lat_tx_en_e1", tx_en, 0);
    check("lat_tx_byte", tx_byte, 8'h4F);
    check("lat_busy", busy, 1);
    check("lat_count_e1", count, 0);
    @(negedge clk);
    check("lat_tx_en_e2", tx_en, 1);
    wait_drain("lat_drain", base + 1, 60);
    check("lat_empty", empty, 1);
    check("lat_rx_byte", rx_mem[base[7:0]], 8'h4F);
    check("lat_tx_byte_hold", tx_byte, 8'h4F);

    // Four back-to-back pushes
    base = rx_n;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; data = msg[i];
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    wr = 1'b0;
    n = 0;
    while ((rx_n < base + 4 || busy) && n < 300) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      n++;
    end
    check("ok_peak", peak, 3);
    repeat (5) @(negedge clk);
    check("ok_pulses", rx_n - base, 4);
    for (int i = 0; i < 4; i++) check($sformatf("ok_byte%0d", i), rx_mem[(base + i) % 256], msg[i]);
    check("ok_no_overlap", overlap_seen, 0);

    // Flush / clear vectors on a stalled line
    do_reset();
    stall = 1'b1;
    base = rx_n;
    for (int i = 0; i < 8; i++) begin
      wr = vecs[i].wr; data = vecs[i].data; flush = vecs[i].flush; clr_ovf = vecs[i].clr;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), count, vecs[i].count);
      check($sformatf("vec%0d_full", i), full, vecs[i].full);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end
    wr = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    stall = 1'b0;
    wait_drain("flush_drain", base + 1, 100);
    repeat (5) @(negedge clk);
    check("flush_rx_cnt", rx_n - base, 1);
    check("flush_rx_byte", rx_mem[base[7:0]], 8'hA1);
    check("flush_count", count, 0);

    // Overfill on a stalled line: 1 in flight + 16 queued, one push dropped
    do_reset();
    stall = 1'b1;
    base = rx_n;
    for (int i = 0; i < 18; i++) begin
      wr = 1'b1; data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_ovf", overflow, 1);
    check("fill_empty", empty, 0);
    wr = 1'b1; data = 8'hEE; clr_ovf = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    check("fill_set_wins", overflow, 1);
    @(negedge clk);
    clr_ovf = 1'b0;
    check("fill_clr", overflow, 0);
    check("fill_count_hold", count, 16);
    stall = 1'b0;
    wait_drain("fill_drain", base + 17, 600);
    repeat (5) @(negedge clk);
    check("fill_rx_cnt", rx_n - base, 17);
    for (int i = 0; i < 17; i++)
      check($sformatf("fill_byte%0d", i), rx_mem[(base + i) % 256], 8'h30 + 8'(i));

    // 40 bytes with a producer that waits on full: pointers wrap
    do_reset();
    base = rx_n;
    for (int b = 0; b < 40; b++) begin
      n = 0;
      while (full === 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (full !== 1'b0) check("wrap_wait_full", full, 0);
      wr = 1'b1; data = 8'(b);
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
    end
    wait_drain("wrap_drain", base + 40, 1200);
    check("wrap_rx_cnt", rx_n - base, 40);
    check("wrap_ovf", overflow, 0);
    for (int i = 0; i < 40; i++)
      check($sformatf("wrap_byte%0d", i), rx_mem[(base + i) % 256], 8'(i));

    // Gap instance: second launch GAP_CYCLES+1 edges after completion is seen
    @(negedge clk);
    g_wr = 1'b1; g_data = 8'h11;
    @(negedge clk);
    g_data = 8'h22;
    @(negedge clk);
    g_wr = 1'b0;
    check("gap_first_tx_en", g_tx_en, 0);
    check("gap_first_byte", g_tx_byte, 8'h11);
    repeat (3) @(negedge clk);
    check("gap_absorb_busy", g_busy, 1);
    check("gap_absorb_tx_en", g_tx_en, 1);
    g_complete = 1'b0;
    repeat (2) @(negedge clk);
    g_complete = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (g_tx_en !== 1'b0 && n < 20);
    check("gap_spacing", n, 7);
    check("gap_second_byte", g_tx_byte, 8'h22);

    // Asynchronous reset while waiting on completion with 3 bytes queued
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; data = 8'h50 + 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_pre_count", count, 3);
    check("arst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_en", tx_en, 1);
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    base = rx_n;
    repeat (40) @(negedge clk);
    check("arst_no_tx", rx_n - base, 0);
    check("arst_idle", busy, 0);
    wr = 1'b1; data = 8'h77;
    @(negedge clk);
    wr = 1'b0;
    wait_drain("arst_drain", base + 1, 60);
    check("arst_new_byte", rx_mem[base[7:0]], 8'h77);

    check("no_overlap_final", overlap_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
